// File: rtl/mc_array_model.sv
// mc_array_model
//   Cycle-accurate behavioural model of the DRAM array behind the memory
//   controller's array interface. It tracks row activate/close from
//   array_banksel_n and stores column writes in a small on-chip memory.
//   Column reads return data after RD_LATENCY cycles. Array-side protocol
//   violations are counted so that controller benches can run closed-loop.
//
//   Optional build macro: MC_ARRAY_CLEAR_EN
//     When defined, the model sweeps the whole memory to zero after reset
//     release, one location per cycle, before it accepts any command.
//     When undefined, memory is not initialised, so unwritten locations read X.
//
//   Ports
//     clk, rst                         clock, async active-high reset
//     array_banksel_n / array_raddr    row open (low); a 1->0 edge activates raddr
//     array_cas_wr / array_caddr_wr    column write strobe and column
//     array_wdata_rdy / array_wdata    write data valid (qualifies cas_wr), data
//     array_cas_rd / array_caddr_rd    column read strobe and column
//     array_rdata_rdy / array_rdata    one-cycle read pulse, data (held between pulses)
//     row_open                         model is in OPEN state
//     proto_err / err_cnt              sticky violation flag, saturating count
module mc_array_model #(
    parameter int ARRAY_ROW_ADDR   = 14,
    parameter int ARRAY_COL_ADDR   = 6,
    parameter int ARRAY_DATA_WIDTH = 64,
    parameter int MEM_ROW_BITS     = 3,
    parameter int RD_LATENCY       = 4,
    parameter int TRCD_MIN         = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        array_banksel_n,
    input  logic [ARRAY_ROW_ADDR-1:0]   array_raddr,
    input  logic                        array_cas_wr,
    input  logic [ARRAY_COL_ADDR-1:0]   array_caddr_wr,
    input  logic                        array_wdata_rdy,
    input  logic [ARRAY_DATA_WIDTH-1:0] array_wdata,
    input  logic                        array_cas_rd,
    input  logic [ARRAY_COL_ADDR-1:0]   array_caddr_rd,
    output logic                        array_rdata_rdy,
    output logic [ARRAY_DATA_WIDTH-1:0] array_rdata,
    output logic                        row_open,
    output logic                        proto_err,
    output logic [7:0]                  err_cnt
);

    localparam int MEM_AW    = MEM_ROW_BITS + ARRAY_COL_ADDR;
    localparam int MEM_DEPTH = 1 << MEM_AW;
    // The activate edge loads trcd_cnt with 1. OPEN is entered once TRCD_MIN
    // cycles have passed since that edge.
    localparam logic [7:0] TRCD_LAST = 8'(TRCD_MIN - 1);

    typedef enum logic [1:0] {IDLE, ACT, OPEN, CLEAR} state_t;

`ifdef MC_ARRAY_CLEAR_EN
    localparam state_t RST_STATE = CLEAR;
    logic [MEM_AW-1:0] clr_addr;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    state_t                      state;
    logic                        banksel_q;
    logic [MEM_ROW_BITS-1:0]     row;
    logic [7:0]                  trcd_cnt;
    logic [ARRAY_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                        act_edge, in_row, any_cas;
    logic                        wr_fire, rd_fire, row_alias, violation;
    logic [ARRAY_DATA_WIDTH-1:0] rd_dat;

    logic [RD_LATENCY:1]         vld_pipe;
    logic [ARRAY_DATA_WIDTH-1:0] dat_pipe [1:RD_LATENCY];

    assign act_edge  = banksel_q & ~array_banksel_n;
    assign in_row    = (state == ACT) || (state == OPEN);
    assign any_cas   = array_cas_wr | array_cas_rd;
    assign wr_fire   = in_row & array_cas_wr & array_wdata_rdy;
    assign rd_fire   = in_row & array_cas_rd;
    assign row_alias = act_edge && (state == IDLE) &&
                       ((array_raddr >> MEM_ROW_BITS) != '0);
    // Async read: a same-cycle write is visible only after the edge, so a
    // colliding read returns the pre-write data.
    assign rd_dat    = mem[{row, array_caddr_rd}];

    // All violation sources are OR-ed, so one cycle adds at most one count.
    // An activate edge outside IDLE can only happen during CLEAR.
    assign violation = (any_cas & ~in_row)
                     | (any_cas & (state == ACT))
                     | (array_cas_wr & array_cas_rd)
                     | (array_cas_wr & ~array_wdata_rdy)
                     | row_alias
                     | (act_edge & (state == CLEAR));

    assign row_open        = (state == OPEN);
    assign array_rdata_rdy = vld_pipe[RD_LATENCY];
    assign array_rdata     = dat_pipe[RD_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RST_STATE;
            banksel_q <= 1'b1;
            row       <= '0;
            trcd_cnt  <= '0;
            proto_err <= 1'b0;
            err_cnt   <= '0;
`ifdef MC_ARRAY_CLEAR_EN
            clr_addr  <= '0;
`endif
        end else begin
            banksel_q <= array_banksel_n;
            if (violation) begin
                proto_err <= 1'b1;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
            case (state)
                IDLE: if (act_edge) begin
                    row      <= array_raddr[MEM_ROW_BITS-1:0];
                    trcd_cnt <= 8'd1;
                    state    <= (TRCD_MIN <= 1) ? OPEN : ACT;
                end
                ACT: begin
                    if (array_banksel_n)            state    <= IDLE;
                    else if (trcd_cnt >= TRCD_LAST) state    <= OPEN;
                    else                            trcd_cnt <= trcd_cnt + 8'd1;
                end
                OPEN: if (array_banksel_n) state <= IDLE;
                CLEAR: begin
`ifdef MC_ARRAY_CLEAR_EN
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == '1) state <= IDLE;
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage has no reset; contents survive rst unless the CLEAR sweep is built in.
    always_ff @(posedge clk) begin
`ifdef MC_ARRAY_CLEAR_EN
        if (state == CLEAR)
            mem[clr_addr] <= '0;
        else
`endif
        if (wr_fire)
            mem[{row, array_caddr_wr}] <= array_wdata;
    end

    // Read pipeline. Data stages load only behind a valid beat, so the last
    // stage holds the most recently delivered word between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 1; i <= RD_LATENCY; i++) dat_pipe[i] <= '0;
        end else begin
            vld_pipe[1] <= rd_fire;
            if (rd_fire) dat_pipe[1] <= rd_dat;
            for (int i = 2; i <= RD_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_mc_array_model.sv
module tb_mc_array_model;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        array_banksel_n = 1'b1;
    logic [13:0] array_raddr = '0;
    logic        array_cas_wr = 1'b0;
    logic [5:0]  array_caddr_wr = '0;
    logic        array_wdata_rdy = 1'b0;
    logic [63:0] array_wdata = '0;
    logic        array_cas_rd = 1'b0;
    logic [5:0]  array_caddr_rd = '0;
    logic        array_rdata_rdy;
    logic [63:0] array_rdata;
    logic        row_open;
    logic        proto_err;
    logic [7:0]  err_cnt;

    mc_array_model dut (
        .clk             (clk),
        .rst             (rst),
        .array_banksel_n (array_banksel_n),
        .array_raddr     (array_raddr),
        .array_cas_wr    (array_cas_wr),
        .array_caddr_wr  (array_caddr_wr),
        .array_wdata_rdy (array_wdata_rdy),
        .array_wdata     (array_wdata),
        .array_cas_rd    (array_cas_rd),
        .array_caddr_rd  (array_caddr_rd),
        .array_rdata_rdy (array_rdata_rdy),
        .array_rdata     (array_rdata),
        .row_open        (row_open),
        .proto_err       (proto_err),
        .err_cnt         (err_cnt)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;

    int          issue_q [$];
    logic [63:0] exp_q   [$];
    int          pq_cyc  [$];
    logic [63:0] pq_dat  [$];

    always @(posedge clk) cyc++;

    always @(negedge clk)
        if (array_rdata_rdy) begin
            pq_cyc.push_back(cyc);
            pq_dat.push_back(array_rdata);
        end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic activate(input logic [13:0] r);
        array_banksel_n = 1'b0;
        array_raddr     = r;
        tick();
    endtask

    task automatic close_row();
        array_banksel_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic wr(input logic [5:0] col, input logic [63:0] d);
        array_cas_wr = 1'b1; array_wdata_rdy = 1'b1;
        array_caddr_wr = col; array_wdata = d;
        tick();
        array_cas_wr = 1'b0; array_wdata_rdy = 1'b0;
    endtask

    // exp_pulse = 0: the read is not expected to deliver (idle or flushed by reset)
    task automatic rd(input logic [5:0] col, input logic [63:0] d, input bit exp_pulse);
        array_cas_rd = 1'b1; array_caddr_rd = col;
        if (exp_pulse) begin
            issue_q.push_back(cyc);
            exp_q.push_back(d);
        end
        tick();
        array_cas_rd = 1'b0;
    endtask

    // Let the pipeline empty, then match every delivered pulse against the
    // expected reads: count, latency of 4 cycles from the sampling edge, data.
    task automatic drain(input string tag);
        repeat (8) tick();
        chk({tag, "_npulse"}, 64'(pq_cyc.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < pq_cyc.size(); i++) begin
            chk($sformatf("%s_lat%0d", tag, i), 64'(pq_cyc[i] - issue_q[i]), 64'd4);
            chk($sformatf("%s_dat%0d", tag, i), pq_dat[i], exp_q[i]);
        end
        issue_q.delete(); exp_q.delete(); pq_cyc.delete(); pq_dat.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst_rdy",   64'(array_rdata_rdy), 64'd0);
        chk("rst_rdata", array_rdata,          64'd0);
        chk("rst_open",  64'(row_open),        64'd0);
        chk("rst_perr",  64'(proto_err),       64'd0);
        chk("rst_cnt",   64'(err_cnt),         64'd0);
        rst = 1'b0;
        tick();

        // 1: activate row 1, wait out tRCD, write then read col 1
        activate(14'd1);
        tick();
        chk("t1_open", 64'(row_open), 64'd1);
        wr(6'd1, 64'd18);
        rd(6'd1, 64'd18, 1'b1);
        drain("t1");
        chk("t1_cnt", 64'(err_cnt), 64'd0);

        // 2: five writes, five back-to-back reads
        for (int i = 1; i <= 5; i++) wr(6'(i), 64'(17 + i));
        for (int i = 1; i <= 5; i++) rd(6'(i), 64'(17 + i), 1'b1);
        drain("t2");
        chk("t2_cnt", 64'(err_cnt), 64'd0);

        // 3: read with the row closed is ignored; rdata keeps last word
        close_row();
        chk("t3_open", 64'(row_open), 64'd0);
        rd(6'd1, 64'd0, 1'b0);
        drain("t3");
        chk("t3_perr",  64'(proto_err), 64'd1);
        chk("t3_cnt",   64'(err_cnt),   64'd1);
        chk("t3_rhold", array_rdata,    64'd22);

        // 4: write inside tRCD still lands; row 8 aliases to row 0
        activate(14'd1);
        wr(6'd6, 64'hA5);
        rd(6'd6, 64'hA5, 1'b1);
        drain("t4a");
        chk("t4_cnt_early", 64'(err_cnt), 64'd2);
        close_row();
        activate(14'h8);
        tick();
        wr(6'd2, 64'd77);
        rd(6'd2, 64'd77, 1'b1);
        drain("t4b");
        chk("t4_cnt_alias", 64'(err_cnt), 64'd3);
        close_row();
        activate(14'd0);
        tick();
        rd(6'd2, 64'd77, 1'b1);
        drain("t4c");
        chk("t4_cnt_row0", 64'(err_cnt), 64'd3);

        // 5: same-cycle write and read on col 3 return pre-write data
        wr(6'd3, 64'd7);
        array_cas_wr = 1'b1; array_wdata_rdy = 1'b1;
        array_caddr_wr = 6'd3; array_wdata = 64'd55;
        rd(6'd3, 64'd7, 1'b1);
        array_cas_wr = 1'b0; array_wdata_rdy = 1'b0;
        rd(6'd3, 64'd55, 1'b1);
        drain("t5");
        chk("t5_cnt", 64'(err_cnt), 64'd4);

        // several violation kinds in one idle cycle count once
        close_row();
        array_cas_wr = 1'b1; array_wdata_rdy = 1'b0;
        rd(6'd0, 64'd0, 1'b0);
        array_cas_wr = 1'b0;
        drain("tmulti");
        chk("tmulti_cnt", 64'(err_cnt), 64'd5);

        // err_cnt saturates at 255
        array_cas_rd = 1'b1;
        repeat (260) tick();
        array_cas_rd = 1'b0;
        drain("tsat");
        chk("tsat_cnt",  64'(err_cnt),   64'd255);
        chk("tsat_perr", 64'(proto_err), 64'd1);

        // 6: reset two cycles after a read drops its pulse
        activate(14'd1);
        tick();
        rd(6'd1, 64'd0, 1'b0);
        tick();
        rst = 1'b1;
        array_banksel_n = 1'b1;
        tick();
        chk("t6_rdy_rst", 64'(array_rdata_rdy), 64'd0);
        tick();
        rst = 1'b0;
        drain("t6");
        chk("t6_cnt",  64'(err_cnt),   64'd0);
        chk("t6_perr", 64'(proto_err), 64'd0);
`ifdef MC_ARRAY_CLEAR_EN
        rd(6'd1, 64'd0, 1'b0);
        drain("t6_clr");
        chk("t6_clr_cnt", 64'(err_cnt), 64'd1);
        repeat (520) tick();
        activate(14'd1);
        tick();
        rd(6'd1, 64'd0, 1'b1);
        drain("t6_zero");
        chk("t6_zero_cnt", 64'(err_cnt), 64'd1);
`else
        activate(14'd1);
        tick();
        rd(6'd1, 64'd18, 1'b1);
        drain("t6_keep");
        chk("t6_keep_cnt", 64'(err_cnt), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
